// File: rtl/alu_rs_if.sv
// Issue, result-broadcast and ALU-dispatch signals of the ALU reservation station.
// The master side is the core (decoder, CDBs, ALU); the slave side is the station.
interface alu_rs_if #(
  parameter int RS_WIDTH  = 3,
  parameter int ROB_WIDTH = 4
);
  logic                 issue_valid;
  logic                 issue_ready;
  logic [3:0]           issue_op;
  logic [31:0]          issue_vj;
  logic [ROB_WIDTH-1:0] issue_qj;
  logic                 issue_pj;
  logic [31:0]          issue_vk;
  logic [ROB_WIDTH-1:0] issue_qk;
  logic                 issue_pk;
  logic [ROB_WIDTH-1:0] issue_rob;

  logic                 alu_cdb_valid;
  logic [ROB_WIDTH-1:0] alu_cdb_rob;
  logic [31:0]          alu_cdb_value;
  logic                 lsb_cdb_valid;
  logic [ROB_WIDTH-1:0] lsb_cdb_rob;
  logic [31:0]          lsb_cdb_value;

  logic                 cal;
  logic [31:0]          a;
  logic [31:0]          b;
  logic [3:0]           alu_op;
  logic [ROB_WIDTH-1:0] rob_out;
  logic [RS_WIDTH:0]    count;

  modport master (
    output issue_valid, issue_op, issue_vj, issue_qj, issue_pj,
           issue_vk, issue_qk, issue_pk, issue_rob,
           alu_cdb_valid, alu_cdb_rob, alu_cdb_value,
           lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_value,
    input  issue_ready, cal, a, b, alu_op, rob_out, count
  );

  modport slave (
    input  issue_valid, issue_op, issue_vj, issue_qj, issue_pj,
           issue_vk, issue_qk, issue_pk, issue_rob,
           alu_cdb_valid, alu_cdb_rob, alu_cdb_value,
           lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_value,
    output issue_ready, cal, a, b, alu_op, rob_out, count
  );
endinterface

// File: rtl/alu_rs.sv
// ALU reservation station: ops wait for operands via CDB snoop; ready op reaches ALU one edge later.
// Issue backpressured by issue_ready (count < depth); dispatch side has no backpressure.
module alu_rs #(
  parameter int RS_WIDTH  = 3,
  parameter int ROB_WIDTH = 4
) (
  input  logic   clk_in,
  input  logic   rst_in,
  input  logic   rdy_in,
  input  logic   clear,
  alu_rs_if.slave bus
);
  localparam int                DEPTH = 1 << RS_WIDTH;
  localparam logic [RS_WIDTH:0] FULL  = (RS_WIDTH+1)'(DEPTH);

  logic                 busy [DEPTH];
  logic [3:0]           op   [DEPTH];
  logic [31:0]          vj   [DEPTH];
  logic [ROB_WIDTH-1:0] qj   [DEPTH];
  logic                 pj   [DEPTH];
  logic [31:0]          vk   [DEPTH];
  logic [ROB_WIDTH-1:0] qk   [DEPTH];
  logic                 pk   [DEPTH];
  logic [ROB_WIDTH-1:0] rob  [DEPTH];

  logic                free_vld, disp_vld, do_issue;
  logic [RS_WIDTH-1:0] free_idx, disp_idx;

  // Returns {pending, value}; the ALU bus takes priority when both carry the tag.
  function automatic logic [32:0] snoop(input logic p, input logic [ROB_WIDTH-1:0] q,
                                        input logic [31:0] v);
    if (p && bus.alu_cdb_valid && bus.alu_cdb_rob == q)
      return {1'b0, bus.alu_cdb_value};
    else if (p && bus.lsb_cdb_valid && bus.lsb_cdb_rob == q)
      return {1'b0, bus.lsb_cdb_value};
    else
      return {p, v};
  endfunction

  // Descending scan so the lowest index wins both selections.
  always_comb begin
    free_vld = 1'b0;
    free_idx = '0;
    disp_vld = 1'b0;
    disp_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_vld = 1'b1;
        free_idx = i[RS_WIDTH-1:0];
      end
      if (busy[i] && !pj[i] && !pk[i]) begin
        disp_vld = 1'b1;
        disp_idx = i[RS_WIDTH-1:0];
      end
    end
  end

  assign bus.issue_ready = (bus.count < FULL);
  assign do_issue        = bus.issue_valid && bus.issue_ready && free_vld;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        busy[i] <= 1'b0;
        op[i]   <= '0;
        vj[i]   <= '0;
        qj[i]   <= '0;
        pj[i]   <= 1'b0;
        vk[i]   <= '0;
        qk[i]   <= '0;
        pk[i]   <= 1'b0;
        rob[i]  <= '0;
      end
      bus.count   <= '0;
      bus.cal     <= 1'b0;
      bus.a       <= '0;
      bus.b       <= '0;
      bus.alu_op  <= '0;
      bus.rob_out <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        for (int i = 0; i < DEPTH; i++) busy[i] <= 1'b0;
        bus.count <= '0;
        bus.cal   <= 1'b0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (busy[i]) begin
            {pj[i], vj[i]} <= snoop(pj[i], qj[i], vj[i]);
            {pk[i], vk[i]} <= snoop(pk[i], qk[i], vk[i]);
          end
        end

        // Selection uses pre-edge operand state, so a same-edge wakeup waits a cycle.
        bus.cal <= disp_vld;
        if (disp_vld) begin
          busy[disp_idx] <= 1'b0;
          bus.a          <= vj[disp_idx];
          bus.b          <= vk[disp_idx];
          bus.alu_op     <= op[disp_idx];
          bus.rob_out    <= rob[disp_idx];
        end

        // free_idx comes from pre-edge busy, so it never aliases the dispatched slot.
        if (do_issue) begin
          busy[free_idx]             <= 1'b1;
          op[free_idx]               <= bus.issue_op;
          qj[free_idx]               <= bus.issue_qj;
          qk[free_idx]               <= bus.issue_qk;
          rob[free_idx]              <= bus.issue_rob;
          {pj[free_idx], vj[free_idx]} <= snoop(bus.issue_pj, bus.issue_qj, bus.issue_vj);
          {pk[free_idx], vk[free_idx]} <= snoop(bus.issue_pk, bus.issue_qk, bus.issue_vk);
        end

        bus.count <= bus.count + (RS_WIDTH+1)'(do_issue) - (RS_WIDTH+1)'(disp_vld);
      end
    end
  end
endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: issue, wakeup, forwarding, full/ordering, clear, freeze, async reset.
module tb_alu_rs;
  logic clk_in, rst_in, rdy_in, clear;
  int   vec_cnt, err_cnt;

  alu_rs_if #(.RS_WIDTH(3), .ROB_WIDTH(4)) bus ();

  alu_rs #(.RS_WIDTH(3), .ROB_WIDTH(4)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .clear  (clear),
    .bus    (bus)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] vj, input logic pj,
                       input logic [3:0] qj, input logic [31:0] vk, input logic pk,
                       input logic [3:0] qk, input logic [3:0] rob);
    bus.issue_op    = op;
    bus.issue_vj    = vj;
    bus.issue_pj    = pj;
    bus.issue_qj    = qj;
    bus.issue_vk    = vk;
    bus.issue_pk    = pk;
    bus.issue_qk    = qk;
    bus.issue_rob   = rob;
    bus.issue_valid = 1'b1;
    tick();
    bus.issue_valid = 1'b0;
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst_in = 1'b1;
    rdy_in = 1'b1;
    clear  = 1'b0;
    bus.issue_valid = 1'b0;
    bus.issue_op = '0; bus.issue_vj = '0; bus.issue_qj = '0; bus.issue_pj = 1'b0;
    bus.issue_vk = '0; bus.issue_qk = '0; bus.issue_pk = 1'b0; bus.issue_rob = '0;
    bus.alu_cdb_valid = 1'b0; bus.alu_cdb_rob = '0; bus.alu_cdb_value = '0;
    bus.lsb_cdb_valid = 1'b0; bus.lsb_cdb_rob = '0; bus.lsb_cdb_value = '0;

    #3;
    chk("rst_cal",   32'(bus.cal), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_ready", 32'(bus.issue_ready), 32'd1);
    chk("rst_a",     bus.a, 32'd0);
    chk("rst_b",     bus.b, 32'd0);
    chk("rst_op",    32'(bus.alu_op), 32'd0);
    chk("rst_rob",   32'(bus.rob_out), 32'd0);
    rst_in = 1'b0;

    // Ready ADD issued at edge 1, dispatched at edge 2.
    issue(4'd0, 32'd5, 1'b0, 4'd0, 32'd7, 1'b0, 4'd0, 4'd3);
    chk("add_e1_cal",   32'(bus.cal), 32'd0);
    chk("add_e1_count", 32'(bus.count), 32'd1);
    tick();
    chk("add_cal", 32'(bus.cal), 32'd1);
    chk("add_a",   bus.a, 32'd5);
    chk("add_b",   bus.b, 32'd7);
    chk("add_op",  32'(bus.alu_op), 32'd0);
    chk("add_rob", 32'(bus.rob_out), 32'd3);
    tick();
    chk("add_e3_cal",   32'(bus.cal), 32'd0);
    chk("add_e3_count", 32'(bus.count), 32'd0);

    // Wakeup via LSB bus.
    issue(4'd1, 32'd0, 1'b1, 4'd6, 32'd2, 1'b0, 4'd0, 4'd4);
    chk("wk_wait_cal", 32'(bus.cal), 32'd0);
    bus.lsb_cdb_valid = 1'b1; bus.lsb_cdb_rob = 4'd6; bus.lsb_cdb_value = 32'd10;
    tick();
    bus.lsb_cdb_valid = 1'b0;
    chk("wk_edge_cal", 32'(bus.cal), 32'd0);
    tick();
    chk("wk_cal", 32'(bus.cal), 32'd1);
    chk("wk_a",   bus.a, 32'd10);
    chk("wk_b",   bus.b, 32'd2);
    chk("wk_op",  32'(bus.alu_op), 32'd1);
    chk("wk_rob", 32'(bus.rob_out), 32'd4);

    // Issue-time forward from ALU bus.
    bus.alu_cdb_valid = 1'b1; bus.alu_cdb_rob = 4'd9; bus.alu_cdb_value = 32'hFFFF_FFFF;
    issue(4'd2, 32'd1, 1'b0, 4'd0, 32'd0, 1'b1, 4'd9, 4'd5);
    bus.alu_cdb_valid = 1'b0;
    tick();
    chk("fw_cal", 32'(bus.cal), 32'd1);
    chk("fw_a",   bus.a, 32'd1);
    chk("fw_b",   bus.b, 32'hFFFF_FFFF);
    chk("fw_rob", 32'(bus.rob_out), 32'd5);

    // Both buses carry the same tag: ALU value wins.
    issue(4'd3, 32'd0, 1'b1, 4'd7, 32'd3, 1'b0, 4'd0, 4'd6);
    bus.alu_cdb_valid = 1'b1; bus.alu_cdb_rob = 4'd7; bus.alu_cdb_value = 32'hAAAA;
    bus.lsb_cdb_valid = 1'b1; bus.lsb_cdb_rob = 4'd7; bus.lsb_cdb_value = 32'hBBBB;
    tick();
    bus.alu_cdb_valid = 1'b0; bus.lsb_cdb_valid = 1'b0;
    tick();
    chk("prio_cal", 32'(bus.cal), 32'd1);
    chk("prio_a",   bus.a, 32'hAAAA);

    // Fill all 8 entries with ops pending on tags 0..7.
    for (int i = 0; i < 8; i++)
      issue(4'(i), 32'd0, 1'b1, 4'(i), 32'(i), 1'b0, 4'd0, 4'(i));
    chk("full_count", 32'(bus.count), 32'd8);
    chk("full_ready", 32'(bus.issue_ready), 32'd0);
    issue(4'd0, 32'h99, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd15);
    chk("drop_count", 32'(bus.count), 32'd8);
    chk("drop_cal",   32'(bus.cal), 32'd0);
    bus.alu_cdb_valid = 1'b1; bus.alu_cdb_rob = 4'd5; bus.alu_cdb_value = 32'h55;
    bus.lsb_cdb_valid = 1'b1; bus.lsb_cdb_rob = 4'd2; bus.lsb_cdb_value = 32'h22;
    tick();
    bus.alu_cdb_valid = 1'b0; bus.lsb_cdb_valid = 1'b0;
    tick();
    chk("ord1_cal", 32'(bus.cal), 32'd1);
    chk("ord1_rob", 32'(bus.rob_out), 32'd2);
    chk("ord1_a",   bus.a, 32'h22);
    chk("ord1_b",   bus.b, 32'd2);
    chk("ord1_op",  32'(bus.alu_op), 32'd2);
    tick();
    chk("ord2_cal",   32'(bus.cal), 32'd1);
    chk("ord2_rob",   32'(bus.rob_out), 32'd5);
    chk("ord2_a",     bus.a, 32'h55);
    chk("ord2_count", 32'(bus.count), 32'd6);
    tick();
    chk("ord3_cal", 32'(bus.cal), 32'd0);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr0_count", 32'(bus.count), 32'd0);
    chk("clr0_ready", 32'(bus.issue_ready), 32'd1);

    // Four entries become ready together, then freeze / clear interplay.
    for (int i = 0; i < 4; i++)
      issue(4'd0, 32'd0, 1'b1, 4'd10, 32'(i), 1'b0, 4'd0, 4'(i));
    bus.alu_cdb_valid = 1'b1; bus.alu_cdb_rob = 4'd10; bus.alu_cdb_value = 32'h100;
    tick();
    bus.alu_cdb_valid = 1'b0;
    chk("c4_count", 32'(bus.count), 32'd4);
    rdy_in = 1'b0; clear = 1'b1;
    tick(); tick();
    chk("frz0_count", 32'(bus.count), 32'd4);
    chk("frz0_cal",   32'(bus.cal), 32'd0);
    rdy_in = 1'b1; clear = 1'b0;
    tick();
    chk("c4_d_cal",   32'(bus.cal), 32'd1);
    chk("c4_d_rob",   32'(bus.rob_out), 32'd0);
    chk("c4_d_count", 32'(bus.count), 32'd3);
    rdy_in = 1'b0; clear = 1'b1;
    tick(); tick();
    chk("frz1_cal",   32'(bus.cal), 32'd1);
    chk("frz1_count", 32'(bus.count), 32'd3);
    chk("frz1_rob",   32'(bus.rob_out), 32'd0);
    rdy_in = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_count", 32'(bus.count), 32'd0);
    chk("clr_cal",   32'(bus.cal), 32'd0);
    chk("clr_a",     bus.a, 32'h100);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("clr_after_cal", 32'(bus.cal), 32'd0);
    end

    // Async reset between edges while cal=1 and one entry still waiting.
    issue(4'd0, 32'd0, 1'b1, 4'd12, 32'd0, 1'b0, 4'd0, 4'd1);
    issue(4'd4, 32'd3, 1'b0, 4'd0, 32'd4, 1'b0, 4'd0, 4'd2);
    tick();
    chk("ar_pre_cal",   32'(bus.cal), 32'd1);
    chk("ar_pre_count", 32'(bus.count), 32'd1);
    #2;
    rst_in = 1'b1;
    #1;
    chk("ar_cal",   32'(bus.cal), 32'd0);
    chk("ar_count", 32'(bus.count), 32'd0);
    chk("ar_a",     bus.a, 32'd0);
    chk("ar_ready", 32'(bus.issue_ready), 32'd1);
    rst_in = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
